// File: rtl/serial_adder.sv
// Bit-serial W-bit adder: one full-adder slice plus a carry flop, LSB first, START/BUSY/DONE handshake.
// Define SERIAL_ADDER_SUB_EN to add a SUB input that turns the operation into A - B.
module serial_adder #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic         sub,
`endif
    output logic [W-1:0] s,
    output logic         cout,
    output logic         busy,
    output logic         done
);

    localparam int CW = $clog2(W) + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DONE
    } state_t;

    state_t         state;
    state_t         state_next;
    logic [W-1:0]   a_reg;
    logic [W-1:0]   b_reg;
    logic [W-1:0]   res_reg;
    logic           carry;
    logic [CW-1:0]  cnt;

    logic           accept;
    logic           last_bit;
    logic           sum_bit;
    logic           carry_next;
    logic [W-1:0]   res_next;
    logic [W-1:0]   b_capture;
    logic           carry_capture;

    // A new operation may be accepted from IDLE or in the single DONE cycle.
    assign accept     = start && (state == ST_IDLE || state == ST_DONE);
    assign last_bit   = (cnt == CW'(W - 1));
    assign sum_bit    = a_reg[0] ^ b_reg[0] ^ carry;
    assign carry_next = (a_reg[0] & b_reg[0]) | (carry & (a_reg[0] ^ b_reg[0]));
    assign res_next   = {sum_bit, res_reg[W-1:1]};

`ifdef SERIAL_ADDER_SUB_EN
    // Subtraction is A + ~B + 1, so the incoming carry is forced high.
    assign b_capture     = sub ? ~b : b;
    assign carry_capture = sub | cin;
`else
    assign b_capture     = b;
    assign carry_capture = cin;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE: if (accept) state_next = ST_RUN;
            ST_RUN:  if (last_bit) state_next = ST_DONE;
            ST_DONE: state_next = accept ? ST_RUN : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Datapath: capture on accept, shift one bit per RUN cycle, publish only on the last bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg   <= '0;
            b_reg   <= '0;
            res_reg <= '0;
            carry   <= 1'b0;
            cnt     <= '0;
            s       <= '0;
            cout    <= 1'b0;
        end else if (accept) begin
            a_reg   <= a;
            b_reg   <= b_capture;
            carry   <= carry_capture;
            res_reg <= '0;
            cnt     <= '0;
        end else if (state == ST_RUN) begin
            a_reg   <= a_reg >> 1;
            b_reg   <= b_reg >> 1;
            carry   <= carry_next;
            res_reg <= res_next;
            cnt     <= cnt + CW'(1);
            if (last_bit) begin
                s    <= res_next;
                cout <= carry_next;
            end
        end
    end

    assign busy = (state == ST_RUN);
    assign done = (state == ST_DONE);

endmodule

// File: tb/tb_serial_adder.sv
// Directed self-checking bench for serial_adder (W=8); subtraction vectors run when SERIAL_ADDER_SUB_EN is defined.
module tb_serial_adder;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub;
`endif
    logic [7:0] s;
    logic       cout;
    logic       busy;
    logic       done;

    int compared   = 0;
    int mismatched = 0;

    serial_adder #(.W(8)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub   (sub),
`endif
        .s     (s),
        .cout  (cout),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Presents operands with START for one edge; returns at the negedge after the accepting edge.
    task automatic applyStimulus(input logic [7:0] av, input logic [7:0] bv, input logic c);
        @(negedge clk);
        a = av;
        b = bv;
        cin = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic waitDone(output int busyCycles, output bit timedOut, output bit sChanged);
        logic [7:0] sPrev;
        sPrev = s;
        busyCycles = 0;
        timedOut = 1'b1;
        sChanged = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (done) begin
                timedOut = 1'b0;
                break;
            end
            if (busy) busyCycles++;
            if (s !== sPrev) sChanged = 1'b1;
            @(negedge clk);
        end
    endtask

    task automatic runOp(input string tag, input logic [7:0] av, input logic [7:0] bv, input logic c,
                         input logic [7:0] expS, input logic expCout);
        int busyCycles;
        bit timedOut;
        bit sChanged;
        applyStimulus(av, bv, c);
        waitDone(busyCycles, timedOut, sChanged);
        checkOutput({tag, "_timeout"}, 32'(timedOut), 32'd0);
        checkOutput({tag, "_busy_cycles"}, 32'(busyCycles), 32'd8);
        checkOutput({tag, "_s_stable"}, 32'(sChanged), 32'd0);
        checkOutput({tag, "_s"}, 32'(s), 32'(expS));
        checkOutput({tag, "_cout"}, 32'(cout), 32'(expCout));
        checkOutput({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        @(negedge clk);
        checkOutput({tag, "_done_pulse"}, 32'(done), 32'd0);
    endtask

    initial begin
        int doneCount;
        int cyc;
        int firstDone;
        int secondDone;

        rst_n = 1'b0;
        start = 1'b0;
        a = '0;
        b = '0;
        cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b0;
`endif

        // Reset held two cycles, then released.
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("rst_s", 32'(s), 32'h00);
        checkOutput("rst_cout", 32'(cout), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);

        runOp("basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);

        runOp("wrap_ff_01", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
        runOp("wrap_ff_ff_c1", 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1);
        runOp("wrap_80_80", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

        // START with new operands during RUN must be ignored.
        applyStimulus(8'h12, 8'h34, 1'b0);
        repeat (2) @(negedge clk);
        a = 8'hFF;
        b = 8'hFF;
        cin = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        begin
            int busyCycles;
            bit timedOut;
            bit sChanged;
            waitDone(busyCycles, timedOut, sChanged);
            checkOutput("ignore_timeout", 32'(timedOut), 32'd0);
            checkOutput("ignore_s", 32'(s), 32'h46);
            checkOutput("ignore_cout", 32'(cout), 32'd0);
        end
        @(negedge clk);

        // Asynchronous reset partway through an operation.
        applyStimulus(8'h55, 8'h66, 1'b0);
        repeat (4) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midrst_s", 32'(s), 32'h00);
        checkOutput("midrst_cout", 32'(cout), 32'd0);
        checkOutput("midrst_busy", 32'(busy), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        doneCount = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (done) doneCount++;
        end
        checkOutput("midrst_no_done", 32'(doneCount), 32'd0);
        checkOutput("midrst_s_after", 32'(s), 32'h00);

        runOp("after_rst", 8'h01, 8'h01, 1'b0, 8'h02, 1'b0);

        // Back-to-back: START held high through the DONE cycle.
        @(negedge clk);
        a = 8'h0F;
        b = 8'h01;
        cin = 1'b0;
        start = 1'b1;
        cyc = 0;
        firstDone = -1;
        secondDone = -1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (firstDone < 0) begin
                    firstDone = cyc;
                    checkOutput("b2b_first_s", 32'(s), 32'h10);
                    checkOutput("b2b_first_cout", 32'(cout), 32'd0);
                    a = 8'h20;
                    b = 8'h22;
                end else begin
                    secondDone = cyc;
                    checkOutput("b2b_second_s", 32'(s), 32'h42);
                    checkOutput("b2b_second_cout", 32'(cout), 32'd0);
                    break;
                end
            end
            if (firstDone >= 0 && cyc == firstDone + 1) start = 1'b0;
        end
        start = 1'b0;
        checkOutput("b2b_both_seen", 32'(firstDone >= 0 && secondDone >= 0), 32'd1);
        checkOutput("b2b_spacing", 32'(secondDone - firstDone), 32'd9);
        @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        sub = 1'b1;
        runOp("sub_10_01", 8'h10, 8'h01, 1'b0, 8'h0F, 1'b1);
        runOp("sub_01_02", 8'h01, 8'h02, 1'b0, 8'hFF, 1'b0);
        sub = 1'b0;
        runOp("sub0_basic", 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
Name: serial_adder

Overview:
Parametrised bit-serial adder. It is the sequential successor of the team's combinational half-adder cell. One full-adder slice plus a carry flip-flop adds two W-bit operands LSB-first, one bit per clock, under a START/BUSY/DONE handshake. It is used where area matters more than latency, and it is the first block in the adder family with state and multi-cycle timing.

Parameters:
W, 8, operand/result width in bits (W >= 2)

Ports:
CLK  input  1  clock, rising-edge active
RST_N  input  1  asynchronous active-low reset
START  input  1  request; sampled only in IDLE or DONE state
A  input  W  operand A; captured on accepted START
B  input  W  operand B; captured on accepted START
CIN  input  1  carry-in; captured on accepted START
S  output  W  registered sum; valid from DONE, held until next DONE
COUT  output  1  registered carry-out; same timing as S
BUSY  output  1  high while in RUN state
DONE  output  1  one-cycle pulse when S/COUT update

Behaviour:
- Reset (RST_N low, asynchronous, any state):
  - S=0, COUT=0, BUSY=0, DONE=0.
  - Internal operand registers, shift register, carry flop and bit counter cleared.
  - State goes to IDLE.
- States: IDLE, RUN, DONE.
- IDLE:
  - START=1 at edge e0 captures A, B and CIN into internal registers, clears the counter and moves to RUN.
  - BUSY=1 after e0.
  - START=0: stay in IDLE.
- RUN: edges e1..eW each process bit i = 0..W-1.
  - sum_i = a_i ^ b_i ^ c
  - c <= (a_i & b_i) | (c & (a_i ^ b_i))
  - sum_i is shifted into the internal result register from the MSB side; the operand registers shift right.
  - Counter runs 0..W-1 and must be ceil(log2(W))+1 bits wide so it cannot wrap early.
  - START is ignored throughout RUN. A, B and CIN changes have no effect.
- Leaving RUN, at edge eW (counter == W-1):
  - S <= final result register including bit W-1; COUT <= final carry.
  - State goes to DONE. BUSY=0, DONE=1 for exactly one cycle.
- DONE:
  - Lasts one cycle, then returns to IDLE.
  - START=1 in this cycle is accepted exactly as in IDLE. Back-to-back operations are allowed with no idle gap.
- Latency: accepted START at e0 gives DONE high after eW, i.e. W+1 edges. Throughput is one result per W+1 cycles.
- Output stability:
  - S and COUT change only at the RUN->DONE transition or at reset.
  - Intermediate partial sums are never visible on S.
- Arithmetic: modulo 2^W. COUT is the carry out of bit W-1.
  - Example: A=2^W-1, B=1 gives S=0, COUT=1.
- Reset mid-RUN: the operation is aborted with no DONE pulse. S and COUT read 0, not the previous result.
- Simultaneous START and reset: reset wins.

Optional Feature:
SERIAL_ADDER_SUB_EN
- Defined:
  - Extra port SUB (input, 1), captured with START.
  - SUB=1 computes A - B: B is inverted on capture, carry-in forced to 1, CIN ignored.
  - COUT=1 means no borrow (A >= B unsigned).
  - SUB=0 behaves exactly as the base block.
- Undefined:
  - No SUB port exists; add only.
  - Netlist is identical to the base block.

Test Plan:
1. Reset: hold RST_N low 2 cycles, then release -> S=0x00, COUT=0, BUSY=0, DONE=0. Assert RST_N low asynchronously between edges -> outputs clear immediately.
2. W=8, A=0x35, B=0x4A, CIN=0, START one cycle -> BUSY high for 8 cycles, DONE pulses 1 cycle at edge 8 after accept, S=0x7F, COUT=0; S stays 0x00 until DONE.
3. Wrap and carry, one operation each:
   - A=0xFF, B=0x01, CIN=0 -> S=0x00, COUT=1.
   - A=0xFF, B=0xFF, CIN=1 -> S=0xFF, COUT=1.
   - A=0x80, B=0x80, CIN=0 -> S=0x00, COUT=1.
4. Ignored START and reset mid-run:
   - Start A=0x12, B=0x34, then pulse START with A=0xFF, B=0xFF during RUN -> result S=0x46, COUT=0.
   - Start a new operation, pull RST_N low at bit 4 -> no DONE, S=0x00.
   - Next operation A=0x01, B=0x01 -> S=0x02.
5. Back-to-back: keep START high through the DONE cycle with A=0x0F, B=0x01 then A=0x20, B=0x22 -> DONE pulses exactly 9 cycles apart, S=0x10 then S=0x42.
6. With SERIAL_ADDER_SUB_EN:
   - SUB=1, A=0x10, B=0x01 -> S=0x0F, COUT=1.
   - SUB=1, A=0x01, B=0x02 -> S=0xFF, COUT=0.
   - SUB=0 repeat of scenario 2 -> S=0x7F.
